// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared decode constants and multiply/divide sequencer state type
package proc_pkg;

    localparam logic [4:0]  OP_RTYPE    = 5'b00000;
    localparam logic [4:0]  ALU_MUL     = 5'b00110;
    localparam logic [4:0]  ALU_DIV     = 5'b00111;

    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_decode.sv
// rtl/muldiv_decode.sv - combinational mul/div R-type detect, shared with the hazard unit
module muldiv_decode
    import proc_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_mul,
    output logic        is_div
);

    logic rtype;

    assign rtype  = (ir[31:27] == OP_RTYPE);
    assign is_mul = rtype && (ir[6:2] == ALU_MUL);
    assign is_div = rtype && (ir[6:2] == ALU_DIV);

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - issues and tracks one mul/div op on the shared multi-cycle unit
module multdiv_sequencer
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic [31:0] dx_a,
    input  logic [31:0] dx_b,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_mult,
    output logic        md_div,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_exc,
    output logic [31:0] res_status
);

    md_state_t        state;
    md_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic             cap_exc;
    logic [31:0]      cap_result;
    logic             is_mul;
    logic             is_div;
    logic             accept;
    logic             ready_hit;
    logic             timed_out;

    muldiv_decode u_decode (
        .ir     (dx_ir),
        .is_mul (is_mul),
        .is_div (is_div)
    );

    assign accept    = (is_mul || is_div) && !flush;
    // Counter 0 is the start-pulse cycle; a ready seen there belongs to the previous op.
    assign ready_hit = md_ready && (cnt != '0);
    assign timed_out = (cnt == CNT_W'(TIMEOUT));

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = accept;
                if (accept) state_next = ST_BUSY;
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (flush)                       state_next = ST_IDLE;
                else if (ready_hit || timed_out) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            md_a       <= '0;
            md_b       <= '0;
            md_mult    <= 1'b0;
            md_div     <= 1'b0;
            op_div     <= 1'b0;
            cap_exc    <= 1'b0;
            cap_result <= '0;
        end else begin
            state   <= state_next;
            md_mult <= 1'b0;
            md_div  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        md_a    <= dx_a;
                        md_b    <= dx_b;
                        op_div  <= is_div;
                        cnt     <= '0;
                        md_mult <= is_mul;
                        md_div  <= is_div;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (!flush) begin
                        if (ready_hit) begin
                            cap_result <= md_result;
                            cap_exc    <= md_exception;
                        end else if (timed_out) begin
                            cap_result <= '0;
                            cap_exc    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Result outputs are decoded from DONE and the capture registers only.
    assign res_valid  = (state == ST_DONE);
    assign res_exc    = res_valid && cap_exc;
    assign res_data   = (res_valid && !cap_exc) ? cap_result : 32'd0;
    assign res_status = res_exc ? (op_div ? RSTATUS_DIV : RSTATUS_MUL) : 32'd0;

endmodule
